// File: rtl/batpu_pkg.sv
// Shared BatPU2 definitions: sequencer states, opcode constants and control-line indices.
package batpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } seq_state_t;

  localparam logic [3:0] OP_HLT = 4'b0001;
  localparam logic [3:0] OP_LOD = 4'b1110;
  localparam logic [3:0] OP_STR = 4'b1111;

  localparam int unsigned CL_MEM_WE = 12;
  localparam int unsigned CL_HLT    = 13;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOD) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// BatPU2 fetch/decode/execute sequencer: ROM handshake, commit gating of decoder
// control lines, LOD/STR memory handshake with timeout, halt state and retire counter.
module cpu_sequencer
  import batpu_pkg::*;
#(
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               rom_req,
  input  logic               rom_ack,
  input  logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] instr_reg,
  output logic [3:0]         opcode,
  input  logic [13:0]        ctrl_in,
  output logic [13:0]        ctrl_out,
  output logic               mem_req,
  input  logic               mem_ack,
  output logic               halted,
  output logic               bus_err,
  output logic [CNT_W-1:0]   retired
);

  localparam int unsigned       TMO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  seq_state_t         r_state;
  logic [INSTR_W-1:0] r_instr;
  logic [TMO_W-1:0]   r_tmo;
  logic [CNT_W-1:0]   r_retired;
  logic               r_rom_req;
  logic               r_mem_req;
  logic               r_halted;
  logic               r_bus_err;
  logic               w_commit;

  // A memory op commits in the very cycle its ack is sampled, not one later.
  assign w_commit  = (r_state == ST_EXEC) || ((r_state == ST_MEM) && mem_ack);
  assign ctrl_out  = w_commit ? ctrl_in : '0;

  assign instr_reg = r_instr;
  assign opcode    = r_instr[INSTR_W-1 -: 4];
  assign rom_req   = r_rom_req;
  assign mem_req   = r_mem_req;
  assign halted    = r_halted;
  assign bus_err   = r_bus_err;
  assign retired   = r_retired;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_instr   <= '0;
      r_tmo     <= '0;
      r_retired <= '0;
      r_rom_req <= 1'b0;
      r_mem_req <= 1'b0;
      r_halted  <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_state   <= ST_FETCH;
            r_rom_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (rom_ack) begin
            r_instr   <= instr;
            r_state   <= ST_DECODE;
            r_rom_req <= 1'b0;
          end
        end
        ST_DECODE: begin
          if (is_mem_op(opcode)) begin
            r_state   <= ST_MEM;
            r_mem_req <= 1'b1;
            r_tmo     <= '0;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_retired <= r_retired + CNT_W'(1);
          if (ctrl_in[CL_HLT]) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state   <= run ? ST_FETCH : ST_IDLE;
            r_rom_req <= run;
          end
        end
        ST_MEM: begin
          // r_tmo counts completed ack-less MEM cycles; the last allowed cycle still accepts an ack.
          if (mem_ack) begin
            r_retired <= r_retired + CNT_W'(1);
            r_mem_req <= 1'b0;
            r_state   <= run ? ST_FETCH : ST_IDLE;
            r_rom_req <= run;
          end else if (r_tmo == TMO_LAST) begin
            r_state   <= ST_HALT;
            r_mem_req <= 1'b0;
            r_halted  <= 1'b1;
            r_bus_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_rom_req <= 1'b0;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer; the bench drives ctrl_in in place of the control decoder.
module tb_cpu_sequencer;
  import batpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        rom_req;
  logic        rom_ack;
  logic [15:0] instr;
  logic [15:0] instr_reg;
  logic [3:0]  opcode;
  logic [13:0] ctrl_in;
  logic [13:0] ctrl_out;
  logic        mem_req;
  logic        mem_ack;
  logic        halted;
  logic        bus_err;
  logic [3:0]  retired;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Narrow counter so the wrap is reachable in a short run.
  cpu_sequencer #(
    .INSTR_W    (16),
    .CNT_W      (4),
    .MEM_TIMEOUT(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .rom_req  (rom_req),
    .rom_ack  (rom_ack),
    .instr    (instr),
    .instr_reg(instr_reg),
    .opcode   (opcode),
    .ctrl_in  (ctrl_in),
    .ctrl_out (ctrl_out),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .halted   (halted),
    .bus_err  (bus_err),
    .retired  (retired)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".rom_req"},   32'(rom_req),   32'h0);
    chk({tag, ".mem_req"},   32'(mem_req),   32'h0);
    chk({tag, ".halted"},    32'(halted),    32'h0);
    chk({tag, ".bus_err"},   32'(bus_err),   32'h0);
    chk({tag, ".retired"},   32'(retired),   32'h0);
    chk({tag, ".instr_reg"}, 32'(instr_reg), 32'h0);
    chk({tag, ".opcode"},    32'(opcode),    32'h0);
    chk({tag, ".ctrl_out"},  32'(ctrl_out),  32'h0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; rom_ack = 1'b0; mem_ack = 1'b0;
    instr = '0; ctrl_in = 14'h3FFF;
    tick(2);
    rst = 1'b0;
    #1;
    chk_reset("reset");

    // LDI, zero-wait ROM
    ctrl_in = 14'h0A5A; run = 1'b1;
    #1;
    chk("ldi.idle_req", 32'(rom_req), 32'h0);
    chk("ldi.idle_ctrl", 32'(ctrl_out), 32'h0);
    tick();
    instr = 16'h8105; rom_ack = 1'b1;
    #1;
    chk("ldi.c1_req", 32'(rom_req), 32'h1);
    chk("ldi.c1_ctrl", 32'(ctrl_out), 32'h0);
    tick();
    rom_ack = 1'b0; run = 1'b0;
    #1;
    chk("ldi.c2_req", 32'(rom_req), 32'h0);
    chk("ldi.c2_ir", 32'(instr_reg), 32'h8105);
    chk("ldi.c2_op", 32'(opcode), 32'h8);
    chk("ldi.c2_ctrl", 32'(ctrl_out), 32'h0);
    tick();
    chk("ldi.c3_ctrl", 32'(ctrl_out), 32'h0A5A);
    chk("ldi.c3_ret", 32'(retired), 32'h0);
    tick();
    chk("ldi.ret", 32'(retired), 32'h1);
    chk("ldi.c4_ctrl", 32'(ctrl_out), 32'h0);
    tick();
    chk("ldi.idle_noreq", 32'(rom_req), 32'h0);

    // LOD with four wait cycles, stray rom_ack during MEM
    run = 1'b1;
    tick();
    instr = 16'hE123; rom_ack = 1'b1;
    tick();
    rom_ack = 1'b0; run = 1'b0;
    #1;
    chk("lod.op", 32'(opcode), 32'hE);
    chk("lod.dec_mreq", 32'(mem_req), 32'h0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      ctrl_in = 14'h1A5A;
      rom_ack = (i == 2);
      instr   = 16'hFFFF;
      #1;
      chk("lod.wait_mreq", 32'(mem_req), 32'h1);
      chk("lod.wait_ctrl", 32'(ctrl_out), 32'h0);
      tick();
    end
    rom_ack = 1'b0; mem_ack = 1'b1;
    #1;
    chk("lod.commit_ctrl", 32'(ctrl_out), 32'h1A5A);
    chk("lod.commit_we", 32'(ctrl_out[CL_MEM_WE]), 32'h1);
    chk("lod.commit_ret", 32'(retired), 32'h1);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("lod.ret", 32'(retired), 32'h2);
    chk("lod.post_mreq", 32'(mem_req), 32'h0);
    chk("lod.post_ctrl", 32'(ctrl_out), 32'h0);
    chk("lod.ir_kept", 32'(instr_reg), 32'hE123);

    // run dropped during a stalled FETCH
    run = 1'b1;
    tick();
    run = 1'b0; rom_ack = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall.req_hold", 32'(rom_req), 32'h1);
      tick();
    end
    instr = 16'h2345; rom_ack = 1'b1;
    tick();
    rom_ack = 1'b0;
    tick();
    ctrl_in = 14'h0A5A;
    #1;
    chk("stall.commit_ctrl", 32'(ctrl_out), 32'h0A5A);
    tick();
    chk("stall.ret", 32'(retired), 32'h3);
    chk("stall.idle_req", 32'(rom_req), 32'h0);
    tick();
    chk("stall.idle_req2", 32'(rom_req), 32'h0);

    // Back-to-back to retired=0xF, then reset mid-MEM
    run = 1'b1; rom_ack = 1'b1; instr = 16'h8105;
    tick();
    tick(36);
    chk("b2b.ret15", 32'(retired), 32'hF);
    instr = 16'hE000;
    tick();
    rom_ack = 1'b0;
    tick();
    chk("rstmem.mreq", 32'(mem_req), 32'h1);
    chk("rstmem.ret", 32'(retired), 32'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_reset("rstmem");

    // Separate wrap of retired
    rom_ack = 1'b1; instr = 16'h8105;
    tick();
    tick(45);
    chk("wrap.ret15", 32'(retired), 32'hF);
    tick(3);
    chk("wrap.ret0", 32'(retired), 32'h0);

    // HLT: commit then sticky halt
    instr = 16'h1000;
    tick();
    rom_ack = 1'b0; ctrl_in = 14'h2011;
    tick();
    chk("hlt.commit_ctrl", 32'(ctrl_out), 32'h2011);
    chk("hlt.commit_bit", 32'(ctrl_out[CL_HLT]), 32'h1);
    chk("hlt.not_yet", 32'(halted), 32'h0);
    tick();
    chk("hlt.halted", 32'(halted), 32'h1);
    chk("hlt.bus_err", 32'(bus_err), 32'h0);
    chk("hlt.ret", 32'(retired), 32'h1);
    chk("hlt.ctrl", 32'(ctrl_out), 32'h0);
    chk("hlt.req", 32'(rom_req), 32'h0);
    rom_ack = 1'b1; mem_ack = 1'b1; instr = 16'h8105;
    tick(3);
    chk("hlt.stay", 32'(halted), 32'h1);
    chk("hlt.ign_req", 32'(rom_req), 32'h0);
    chk("hlt.ign_ir", 32'(instr_reg), 32'h1000);
    chk("hlt.ign_ret", 32'(retired), 32'h1);
    chk("hlt.ign_ctrl", 32'(ctrl_out), 32'h0);
    rom_ack = 1'b0; mem_ack = 1'b0; run = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_reset("hltrst");

    // Ack on the last allowed MEM cycle still commits
    run = 1'b1;
    tick();
    instr = 16'hE0AB; rom_ack = 1'b1;
    tick();
    rom_ack = 1'b0; run = 1'b0; ctrl_in = 14'h1111;
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("edge.wait_ctrl", 32'(ctrl_out), 32'h0);
      chk("edge.wait_mreq", 32'(mem_req), 32'h1);
      tick();
    end
    mem_ack = 1'b1;
    #1;
    chk("edge.commit_ctrl", 32'(ctrl_out), 32'h1111);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("edge.halted", 32'(halted), 32'h0);
    chk("edge.bus_err", 32'(bus_err), 32'h0);
    chk("edge.ret", 32'(retired), 32'h1);
    chk("edge.mreq", 32'(mem_req), 32'h0);

    // STR with no ack: timeout halt
    run = 1'b1;
    tick();
    instr = 16'hF0AB; rom_ack = 1'b1;
    tick();
    rom_ack = 1'b0; run = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("tmo.wait_mreq", 32'(mem_req), 32'h1);
      chk("tmo.wait_halt", 32'(halted), 32'h0);
      tick();
    end
    chk("tmo.halted", 32'(halted), 32'h1);
    chk("tmo.bus_err", 32'(bus_err), 32'h1);
    chk("tmo.mreq", 32'(mem_req), 32'h0);
    chk("tmo.ret", 32'(retired), 32'h1);
    chk("tmo.ctrl", 32'(ctrl_out), 32'h0);
    mem_ack = 1'b1;
    #1;
    chk("tmo.late_ack_ctrl", 32'(ctrl_out), 32'h0);
    tick();
    chk("tmo.late_ack_ret", 32'(retired), 32'h1);
    chk("tmo.late_ack_halt", 32'(halted), 32'h1);
    mem_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
